// File: rtl/dma_rd_streamer_pkg.sv
// Shared AXI encodings and DMA read-engine types/constants, plus default widths
// for builds that do not predefine DMA_ADDR_WIDTH / DMA_DATA_WIDTH / DMA_FIFO_DEPTH.
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 16
`endif

package axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // AxSIZE encoding: log2 of bytes per beat
  function automatic logic [2:0] axi_size(input int bytes_per_beat);
    return 3'($clog2(bytes_per_beat));
  endfunction
endpackage

package dma_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_rd_st_e;

  localparam int DMA_MAX_BURST  = 16;
  localparam int DMA_PAGE_BYTES = 4096;
endpackage

// File: rtl/dma_rd_streamer_if.sv
// AXI read address/data channels plus the downstream FIFO write port of the DMA read engine.
interface dma_rd_if #(
  parameter int ADDR_WIDTH = `DMA_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DMA_DATA_WIDTH,
  parameter int FIFO_DEPTH = `DMA_FIFO_DEPTH
);
  logic [ADDR_WIDTH-1:0]       ar_addr;
  logic [7:0]                  ar_len;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [DATA_WIDTH-1:0]       r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic                        r_valid;
  logic                        r_ready;
  logic                        fifo_write;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_free;

  modport master (
    output ar_addr, ar_len, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready,
    output fifo_write, fifo_data,
    input  fifo_free
  );

  modport slave (
    input  ar_addr, ar_len, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_valid,
    input  r_ready,
    input  fifo_write, fifo_data,
    output fifo_free
  );
endinterface

// File: rtl/dma_rd_streamer_burst_calc.sv
// Combinational burst sizing: smallest of the burst cap, remaining beats and beats left in the 4KB page.
module dma_rd_burst_calc
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = DMA_MAX_BURST,
  parameter int BURST_W    = $clog2(MAX_BURST) + 1
) (
  input  logic [11:0]           page_off,
  input  logic [ADDR_WIDTH-1:0] beats_left,
  output logic [BURST_W-1:0]    burst
);
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [12:0]           beats_to_page;
  logic [ADDR_WIDTH-1:0] lim;

  // Alignment guarantees beats_to_page is never zero, so a burst never straddles a page
  always_comb begin
    beats_to_page = (13'(DMA_PAGE_BYTES) - {1'b0, page_off}) >> BEAT_SHIFT;
    lim = beats_left;
    if (lim > ADDR_WIDTH'(MAX_BURST)) lim = ADDR_WIDTH'(MAX_BURST);
    if (lim > ADDR_WIDTH'(beats_to_page)) lim = ADDR_WIDTH'(beats_to_page);
    burst = BURST_W'(lim);
  end
endmodule

// File: rtl/dma_rd_streamer.sv
// DMA read engine: credit-gated AXI4 INCR read bursts streamed straight into the data FIFO.
// Optional DMA_RD_PERF_EN adds saturating perf_beats_o / perf_stall_o counters.
module dma_rd_streamer
  import dma_pkg::*;
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = `DMA_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DMA_DATA_WIDTH,
  parameter int FIFO_DEPTH = `DMA_FIFO_DEPTH,
  parameter int MAX_BURST  = DMA_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] num_bytes_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
`ifdef DMA_RD_PERF_EN
  output logic [31:0]           perf_beats_o,
  output logic [31:0]           perf_stall_o,
`endif
  dma_rd_if.master              bus
);
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  // A burst larger than the FIFO could never earn credit, so cap it at the depth
  localparam int EFF_BURST  = (MAX_BURST < FIFO_DEPTH) ? MAX_BURST : FIFO_DEPTH;
  localparam int BURST_W    = $clog2(EFF_BURST) + 1;
  localparam int RES_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int CW         = RES_W + 1;

  dma_rd_st_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, beats_left_q;
  logic [RES_W-1:0]      reserved_q;
  logic                  err_q, aborted_q, ar_hold_q;
  logic [BURST_W-1:0]    burst;
  logic                  credit_ok, ar_valid, ar_hs, r_ready, r_beat, accept;

  dma_rd_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (EFF_BURST),
    .BURST_W    (BURST_W)
  ) u_burst_calc (
    .page_off   (addr_q[11:0]),
    .beats_left (beats_left_q),
    .burst      (burst)
  );

  assign credit_ok = CW'(bus.fifo_free) >= CW'(reserved_q) + CW'(burst);
  assign accept    = (state_q == IDLE) && start_i;
  assign ar_hs     = ar_valid && bus.ar_ready;
  assign r_beat    = bus.r_valid && r_ready;

  assign bus.ar_valid   = ar_valid;
  assign bus.ar_addr    = addr_q;
  assign bus.ar_len     = (burst == '0) ? 8'd0 : 8'(burst - BURST_W'(1));
  assign bus.r_ready    = r_ready;
  assign bus.fifo_write = r_beat && !aborted_q;
  assign bus.fifo_data  = bus.r_data;
  assign err_o          = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // An AR already on the bus (ar_hold_q) stays up through an abort until it is accepted
  always_comb begin
    state_d  = state_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    r_ready  = 1'b0;
    ar_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (num_bytes_i == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_o   = 1'b1;
        r_ready  = 1'b1;
        ar_valid = ar_hold_q || (credit_ok && !aborted_q && (burst != '0));
        if (ar_valid && bus.ar_ready) begin
          if (abort_i || aborted_q || (beats_left_q == ADDR_WIDTH'(burst))) state_d = DRAIN;
        end else if ((abort_i || aborted_q) && !ar_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o  = 1'b1;
        r_ready = 1'b1;
        if (reserved_q == '0) state_d = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Credits: a burst reserves its beats at AR handshake, each R beat returns one
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      beats_left_q <= '0;
      reserved_q   <= '0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      ar_hold_q    <= 1'b0;
    end else begin
      ar_hold_q  <= ar_valid && !bus.ar_ready;
      reserved_q <= reserved_q + (ar_hs ? RES_W'(burst) : RES_W'(0)) - (r_beat ? RES_W'(1) : RES_W'(0));
      if (ar_hs) begin
        addr_q       <= addr_q + (ADDR_WIDTH'(burst) << BEAT_SHIFT);
        beats_left_q <= beats_left_q - ADDR_WIDTH'(burst);
      end
      if (r_beat && (bus.r_resp != AXI_RESP_OKAY)) err_q <= 1'b1;
      if ((state_q == RUN) && abort_i) begin
        aborted_q <= 1'b1;
        err_q     <= 1'b1;
      end
      if (accept) begin
        addr_q       <= src_addr_i;
        beats_left_q <= num_bytes_i >> BEAT_SHIFT;
        reserved_q   <= '0;
        err_q        <= 1'b0;
        aborted_q    <= 1'b0;
      end
    end
  end

`ifdef DMA_RD_PERF_EN
  logic stall;
  assign stall = (state_q == RUN) && !aborted_q && (burst != '0) && !ar_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_beats_o <= '0;
      perf_stall_o <= '0;
    end else if (accept) begin
      perf_beats_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (bus.fifo_write && (perf_beats_o != '1)) perf_beats_o <= perf_beats_o + 32'd1;
      if (stall && (perf_stall_o != '1))          perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dma_rd_streamer.sv
// Directed bench for dma_rd_streamer: vector table of whole transfers against a small AXI slave model,
// plus hand-written credit, AR-hold, abort and reset sequences.
module tb_dma_rd_streamer;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FD = 16;
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, abort_i;
  logic [AW-1:0] src_addr_i, num_bytes_i;
  logic          busy_o, done_o, err_o;
`ifdef DMA_RD_PERF_EN
  logic [31:0]   perf_beats_o, perf_stall_o;
`endif

  dma_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  dma_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_BURST(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .num_bytes_i  (num_bytes_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
`ifdef DMA_RD_PERF_EN
    .perf_beats_o (perf_beats_o),
    .perf_stall_o (perf_stall_o),
`endif
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] bytes;
    int          err_beat;
    int          n_ar;
    logic [31:0] a0;
    int          l0;
    logic [31:0] a1;
    int          l1;
    int          pushes;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        last;
  } beat_t;

  vec_t        vecs[6];
  beat_t       rq[$];
  logic [31:0] ar_log_addr[$];
  int          ar_log_len[$];
  int          push_cnt, rbeat_cnt, done_cnt, data_bad, r_wait, job_push, job_rbeat;
  logic [31:0] job_addr;
  logic        ar_ready_en;
  int          err_beat;
  int          checks = 0;
  int          errors = 0;

  // AXI slave + FIFO observer: drives on the falling edge, samples 4ns later
  initial begin
    push_cnt = 0; rbeat_cnt = 0; done_cnt = 0; data_bad = 0; r_wait = 0;
    job_push = 0; job_rbeat = 0; job_addr = '0;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0;
    bus.r_resp = AXI_RESP_OKAY; bus.r_last = 1'b0;
    forever begin
      @(negedge clk);
      bus.ar_ready = ar_ready_en;
      if (rq.size() > 0 && r_wait == 0) begin
        bus.r_valid = 1'b1;
        bus.r_data  = rq[0].addr ^ PAT;
        bus.r_last  = rq[0].last;
        bus.r_resp  = (job_rbeat == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
        bus.r_valid = 1'b0;
        bus.r_last  = 1'b0;
        bus.r_resp  = AXI_RESP_OKAY;
        if (r_wait > 0) r_wait--;
      end
      #4;
      if (start_i && !busy_o) begin
        job_addr = src_addr_i; job_push = 0; job_rbeat = 0;
      end
      if (bus.ar_valid && bus.ar_ready) begin
        ar_log_addr.push_back(bus.ar_addr);
        ar_log_len.push_back(int'(bus.ar_len));
        if (rq.size() == 0) r_wait = 3;
        for (int i = 0; i <= int'(bus.ar_len); i++) begin
          beat_t b;
          b.addr = bus.ar_addr + 32'(4 * i);
          b.last = (i == int'(bus.ar_len));
          rq.push_back(b);
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        void'(rq.pop_front());
        rbeat_cnt++; job_rbeat++;
      end
      if (bus.fifo_write) begin
        if (bus.fifo_data !== ((job_addr + 32'(4 * job_push)) ^ PAT)) data_bad++;
        push_cnt++; job_push++;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] addr, input logic [31:0] bytes);
    @(negedge clk);
    start_i = 1'b1; src_addr_i = addr; num_bytes_i = bytes;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base_done);
    for (int i = 0; i < 400 && done_cnt == base_done; i++) @(negedge clk);
    @(negedge clk);
    #4;
  endtask

  task automatic apply_stimulus(input int k);
    int base_ar, base_push, base_done, base_bad;
    base_ar = ar_log_addr.size(); base_push = push_cnt; base_done = done_cnt; base_bad = data_bad;
    err_beat = vecs[k].err_beat;
    start_job(vecs[k].addr, vecs[k].bytes);
    wait_done(base_done);
    check_output($sformatf("v%0d_done", k), 64'(done_cnt - base_done), 64'(1));
    check_output($sformatf("v%0d_ar_count", k), 64'(ar_log_addr.size() - base_ar), 64'(vecs[k].n_ar));
    if (vecs[k].n_ar >= 1 && ar_log_addr.size() > base_ar) begin
      check_output($sformatf("v%0d_ar0_addr", k), 64'(ar_log_addr[base_ar]), 64'(vecs[k].a0));
      check_output($sformatf("v%0d_ar0_len", k), 64'(ar_log_len[base_ar]), 64'(vecs[k].l0));
    end
    if (vecs[k].n_ar >= 2 && ar_log_addr.size() > base_ar + 1) begin
      check_output($sformatf("v%0d_ar1_addr", k), 64'(ar_log_addr[base_ar+1]), 64'(vecs[k].a1));
      check_output($sformatf("v%0d_ar1_len", k), 64'(ar_log_len[base_ar+1]), 64'(vecs[k].l1));
    end
    check_output($sformatf("v%0d_pushes", k), 64'(push_cnt - base_push), 64'(vecs[k].pushes));
    check_output($sformatf("v%0d_data", k), 64'(data_bad - base_bad), 64'(0));
    check_output($sformatf("v%0d_err", k), 64'(err_o), 64'(vecs[k].err));
    check_output($sformatf("v%0d_busy_after", k), 64'(busy_o), 64'(0));
    err_beat = -1;
  endtask

  initial begin
    int  base_ar, base_push, base_done, base_rb;
    logic seen;

    //            addr          bytes   errb n_ar a0            l0  a1            l1 push err
    vecs[0] = '{32'h0000_1000, 32'd64,  -1,  1,  32'h0000_1000, 15, 32'h0,         0, 16, 1'b0};
    vecs[1] = '{32'h0000_0FF8, 32'd32,  -1,  2,  32'h0000_0FF8,  1, 32'h0000_1000, 5,  8, 1'b0};
    vecs[2] = '{32'h0000_2000, 32'd4,   -1,  1,  32'h0000_2000,  0, 32'h0,         0,  1, 1'b0};
    vecs[3] = '{32'h0000_3000, 32'd0,   -1,  0,  32'h0,          0, 32'h0,         0,  0, 1'b0};
    vecs[4] = '{32'h0000_1000, 32'd64,   3,  1,  32'h0000_1000, 15, 32'h0,         0, 16, 1'b1};
    vecs[5] = '{32'h0000_4000, 32'd100, -1,  2,  32'h0000_4000, 15, 32'h0000_4040, 8, 25, 1'b0};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; src_addr_i = '0; num_bytes_i = '0;
    bus.fifo_free = 5'd16; ar_ready_en = 1'b1; err_beat = -1;
    repeat (3) @(negedge clk);
    #4;
    check_output("rst_busy", 64'(busy_o), 64'(0));
    check_output("rst_done", 64'(done_o), 64'(0));
    check_output("rst_err", 64'(err_o), 64'(0));
    check_output("rst_ar_valid", 64'(bus.ar_valid), 64'(0));
    check_output("rst_r_ready", 64'(bus.r_ready), 64'(0));
    check_output("rst_fifo_write", 64'(bus.fifo_write), 64'(0));
    check_output("rst_ar_addr", 64'(bus.ar_addr), 64'(0));
    check_output("rst_ar_len", 64'(bus.ar_len), 64'(0));
    rst = 1'b0;

    for (int k = 0; k < 6; k++) apply_stimulus(k);

    // Credit-blocked: only 4 free slots, 16-beat burst must wait
    base_ar = ar_log_addr.size(); base_push = push_cnt; base_done = done_cnt;
    bus.fifo_free = 5'd4;
    start_job(32'h0000_5000, 32'd64);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      if (bus.ar_valid) seen = 1'b1;
    end
    check_output("credit_ar_blocked", 64'(seen), 64'(0));
    check_output("credit_busy", 64'(busy_o), 64'(1));
    @(negedge clk);
    bus.fifo_free = 5'd16;
    wait_done(base_done);
    check_output("credit_ar_count", 64'(ar_log_addr.size() - base_ar), 64'(1));
    if (ar_log_len.size() > base_ar) check_output("credit_ar_len", 64'(ar_log_len[base_ar]), 64'(15));
    check_output("credit_pushes", 64'(push_cnt - base_push), 64'(16));
`ifdef DMA_RD_PERF_EN
    check_output("perf_stall", 64'(perf_stall_o), 64'(11));
    check_output("perf_beats", 64'(perf_beats_o), 64'(16));
`endif

    // AR held without ready for 5 cycles must stay stable
    base_ar = ar_log_addr.size(); base_push = push_cnt; base_done = done_cnt;
    ar_ready_en = 1'b0;
    start_job(32'h0000_6000, 32'd64);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #4;
      seen = bus.ar_valid;
    end
    check_output("hold_valid_seen", 64'(seen), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      check_output($sformatf("hold_stable_c%0d", i), 64'({bus.ar_valid, bus.ar_addr, bus.ar_len}),
                   64'({1'b1, 32'h0000_6000, 8'd15}));
    end
    ar_ready_en = 1'b1;
    wait_done(base_done);
    check_output("hold_ar_count", 64'(ar_log_addr.size() - base_ar), 64'(1));
    check_output("hold_pushes", 64'(push_cnt - base_push), 64'(16));

    // Abort after the first AR of a 64-beat job
    base_ar = ar_log_addr.size(); base_push = push_cnt; base_done = done_cnt; base_rb = rbeat_cnt;
    start_job(32'h0000_7000, 32'd256);
    for (int i = 0; i < 20 && ar_log_addr.size() == base_ar; i++) begin
      @(negedge clk);
      #4;
    end
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_done(base_done);
    check_output("abort_done", 64'(done_cnt - base_done), 64'(1));
    check_output("abort_ar_count", 64'(ar_log_addr.size() - base_ar), 64'(1));
    check_output("abort_r_beats", 64'(rbeat_cnt - base_rb), 64'(16));
    check_output("abort_pushes", 64'(push_cnt - base_push), 64'(0));
    check_output("abort_err", 64'(err_o), 64'(1));
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    #4;
    abort_i = 1'b0;
    check_output("idle_abort_busy", 64'(busy_o), 64'(0));
    check_output("idle_abort_err_sticky", 64'(err_o), 64'(1));

    // Reset while an AR is waiting for ready
    ar_ready_en = 1'b0;
    start_job(32'h0000_8000, 32'd64);
    @(negedge clk);
    #4;
    check_output("rst_mid_pre_valid", 64'(bus.ar_valid), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4;
    check_output("rst_mid_ar_valid", 64'(bus.ar_valid), 64'(0));
    check_output("rst_mid_busy", 64'(busy_o), 64'(0));
    check_output("rst_mid_err", 64'(err_o), 64'(0));
    rst = 1'b0;
    ar_ready_en = 1'b1;

    apply_stimulus(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
